mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ic_req  input  1  I-cache miss fill request, held high until ic_done.
REQ-004 SHALL have port ic_addr  input  16  I-cache miss byte address.
REQ-005 SHALL have port dc_req  input  1  D-cache request (fill or write), held high until dc_done.
REQ-006 SHALL have port dc_wr  input  1  1 = single-word write-through, 0 = block fill.
REQ-007 SHALL have port dc_addr  input  16  D-side byte address.
REQ-008 SHALL have port dc_wdata  input  16  D-side write data.
REQ-009 SHALL have port mem_en, mem_wr  output  1 each  main-memory enable and write strobe.
REQ-010 SHALL have port mem_addr, mem_wdata  output  16 each  main-memory address and write data.
REQ-011 SHALL have port mem_rdata  input  16  main-memory read data.
REQ-012 SHALL have port mem_valid  input  1  mem_rdata valid this cycle.
REQ-013 SHALL have port ic_fill_we, dc_fill_we  output  1 each  per-side cache-line word write enable.
REQ-014 SHALL have port fill_word  output  3  word index within line being filled.
REQ-015 SHALL have port fill_data  output  16  fill data, equal to mem_rdata.
REQ-016 SHALL have port ic_done, dc_done  output  1 each  one-cycle completion pulse.
REQ-017 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, IFILL, DFILL, DWRITE.
REQ-019 IDLE SHALL grant on the rising edge: dc_req&dc_wr -> DWRITE; dc_req&~dc_wr -> DFILL; ic_req -> IFILL.
REQ-020 When both ic_req and dc_req are high in IDLE, SHALL grant the side not serviced last (round-robin); after reset the D side wins.
REQ-021 SHALL latch the address (and dc_wdata) at the grant edge; later changes to requester inputs SHALL be ignored until the transaction ends.
REQ-022 DWRITE SHALL last one cycle: mem_en=1, mem_wr=1, mem_addr and mem_wdata = latched values, dc_done=1; next state IDLE.
REQ-023 In a fill state, SHALL issue 8 reads in the first 8 cycles: mem_en=1, mem_wr=0, mem_addr={base[15:4], issue_cnt[2:0], 1'b0}, with issue_cnt running 0..7; mem_en=0 afterwards.
REQ-024 In a fill state, each mem_valid SHALL assert the granted side's fill_we with fill_word=ret_cnt, then increment ret_cnt (3-bit).
REQ-025 On the 8th mem_valid, SHALL assert the granted side's done in the same cycle and return to IDLE on the next edge.
REQ-026 mem_valid in IDLE or DWRITE SHALL be ignored: no fill_we, no counter change.
REQ-027 Requesters deassert req on the edge where done is high; IDLE SHALL NOT re-grant a request that has just completed.
REQ-028 A request deasserted mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-029 Outputs SHALL be 0 when inactive: mem_en, mem_wr, fill_we, and done are 0 outside their defined cycles.
REQ-030 fill_word and fill_data SHALL be don't-care when both fill_we are 0.

Reset
REQ-031 On rst_n low, SHALL go immediately to IDLE, regardless of cycle.
REQ-032 On rst_n low, SHALL clear issue_cnt, ret_cnt, latched address/data, and the round-robin flag (D first).
REQ-033 On rst_n low, SHALL drive all outputs to 0.
REQ-034 Reset during a fill SHALL abandon the fill, with no done pulse; late mem_valid responses after reset SHALL be ignored.

Verification (4-cycle pipelined memory model)
REQ-035 ic_req=1, ic_addr=0x1236 -> reads 0x1230..0x123E in cycles 1-8; ic_fill_we words 0..7 in cycles 5-12; ic_done in cycle 12; busy low in cycle 13.
REQ-036 dc_req=1, dc_wr=1, dc_addr=0x0040, dc_wdata=0xBEEF -> exactly one cycle with mem_en=1, mem_wr=1, 0x0040/0xBEEF, and dc_done=1.
REQ-037 ic_req and dc_req (fill) raised together, then repeated -> DFILL serviced first, IFILL second, then D again; no side is starved.
REQ-038 rst_n pulsed low during the 3rd fill return -> all outputs 0 at once; the remaining 5 mem_valid pulses cause no fill_we; the next request fills from word 0.
REQ-039 Spurious mem_valid=1 in IDLE -> no fill_we, no done; a following fill still returns exactly 8 words.
REQ-040 ic_req dropped mid-fill -> all 8 words are still written and ic_done pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one main-memory port between an I-cache miss engine and a
//   D-cache (fill or single-word write-through). Fills are 8 pipelined word
//   reads of a 16-byte line; D writes are a single one-cycle memory write.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ic_req, ic_addr         I-side fill request and byte address
//   dc_req, dc_wr,          D-side request, 1 = write-through / 0 = fill,
//   dc_addr, dc_wdata       byte address and write data
//   mem_en, mem_wr,         memory strobe, write strobe,
//   mem_addr, mem_wdata     address and write data
//   mem_rdata, mem_valid    memory read return (any latency, in order)
//   ic_fill_we, dc_fill_we  per-side line-word write enable
//   fill_word, fill_data    word index in line and the data to write
//   ic_done, dc_done        one-cycle completion pulse per side
//   busy                    transaction in progress
//   dbgState                current FSM state, for checkers
//
// Request/done handshake: a requester raises req and holds it, with its
// address/data stable, until it sees its done pulse; it drops req on the
// rising edge where done is high. Address and data are captured on the grant
// edge, so the requester may change them (or drop req) afterwards without
// affecting the transaction in flight.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic        ic_fill_we,
  output logic        dc_fill_we,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        ic_done,
  output logic        dc_done,
  output logic        busy,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  issueCnt;   // bit 3 set once all 8 reads have been issued
  logic [2:0]  retCnt;     // number of words returned so far
  logic [15:0] latAddr;
  logic [15:0] latData;
  logic        lastD;      // 1 = D side was granted most recently

  logic grantD;
  logic inFill;
  logic issuing;
  logic fillHit;
  logic lastRet;

  // D wins when it is the only requester, or when I was served last.
  always_comb begin
    grantD  = dc_req && (!ic_req || !lastD);
    inFill  = (state == IFILL) || (state == DFILL);
    issuing = inFill && !issueCnt[3];
    fillHit = inFill && mem_valid;
    lastRet = fillHit && (retCnt == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      issueCnt <= 4'd0;
      retCnt   <= 3'd0;
      latAddr  <= 16'd0;
      latData  <= 16'd0;
      lastD    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issueCnt <= 4'd0;
          retCnt   <= 3'd0;
          if (grantD) begin
            latAddr <= dc_addr;
            latData <= dc_wdata;
            lastD   <= 1'b1;
            state   <= dc_wr ? DWRITE : DFILL;
          end else if (ic_req) begin
            latAddr <= ic_addr;
            lastD   <= 1'b0;
            state   <= IFILL;
          end
        end
        IFILL, DFILL: begin
          if (!issueCnt[3]) issueCnt <= issueCnt + 4'd1;
          if (mem_valid) begin
            retCnt <= retCnt + 3'd1;
            if (retCnt == 3'd7) state <= IDLE;
          end
        end
        DWRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only (plus mem_valid for the
  // return path), so they drop to 0 the instant reset clears the state.
  always_comb begin
    mem_en     = issuing || (state == DWRITE);
    mem_wr     = (state == DWRITE);
    mem_addr   = 16'd0;
    mem_wdata  = 16'd0;
    if (state == DWRITE) begin
      mem_addr  = latAddr;
      mem_wdata = latData;
    end else if (issuing) begin
      mem_addr = {latAddr[15:4], issueCnt[2:0], 1'b0};
    end
    ic_fill_we = (state == IFILL) && mem_valid;
    dc_fill_we = (state == DFILL) && mem_valid;
    fill_word  = fillHit ? retCnt : 3'd0;
    fill_data  = fillHit ? mem_rdata : 16'd0;
    ic_done    = (state == IFILL) && lastRet;
    dc_done    = ((state == DFILL) && lastRet) || (state == DWRITE);
    busy       = (state != IDLE);
    dbgState   = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ic_req = 1'b0;
  logic [15:0] ic_addr = 16'd0;
  logic        dc_req = 1'b0;
  logic        dc_wr = 1'b0;
  logic [15:0] dc_addr = 16'd0;
  logic [15:0] dc_wdata = 16'd0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic        ic_fill_we, dc_fill_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        ic_done, dc_done, busy;
  logic [1:0]  dbg_state;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
    .fill_word(fill_word), .fill_data(fill_data),
    .ic_done(ic_done), .dc_done(dc_done), .busy(busy),
    .dbgState(dbg_state)
  );

  // ---------------- 4-cycle pipelined memory model ----------------
  // A read sampled at the edge ending cycle k returns in cycle k+4.
  // Read data is address ^ 16'hA5A5. spur_valid injects stray returns.
  logic        pv [4];
  logic [15:0] pa [4];
  logic        spur_valid = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'd0;
    end
  end

  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign mem_valid = pv[3] | spur_valid;
  assign mem_rdata = pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge of the cycle where the request is visible
  // (cycle 0). Walks cycles 1..13 and checks the full fill timeline.
  // The serviced request is dropped on done, or early at drop_c.
  task automatic do_fill(input bit is_d, input logic [15:0] addr, input int drop_c);
    logic [15:0] base;
    logic [15:0] a;
    logic [15:0] d;
    logic        own_we, oth_we, own_done, oth_done;
    base = {addr[15:4], 4'h0};
    exp_q.delete();
    for (int w = 0; w < 8; w++) begin
      a = base + 16'(2 * w);
      exp_q.push_back(a ^ 16'hA5A5);
    end
    for (int c = 1; c <= 13; c++) begin
      step();
      own_we   = is_d ? dc_fill_we : ic_fill_we;
      oth_we   = is_d ? ic_fill_we : dc_fill_we;
      own_done = is_d ? dc_done : ic_done;
      oth_done = is_d ? ic_done : dc_done;
      check_eq("fill_mem_en", mem_en, (c <= 8) ? 1 : 0);
      check_eq("fill_mem_wr", mem_wr, 0);
      if (c <= 8) check_eq("fill_mem_addr", mem_addr, base + 16'(2 * (c - 1)));
      check_eq("fill_we", own_we, (c >= 5 && c <= 12) ? 1 : 0);
      check_eq("fill_we_other", oth_we, 0);
      if (c >= 5 && c <= 12) begin
        check_eq("fill_word", fill_word, c - 5);
        d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check_eq("fill_data", fill_data, d);
      end
      check_eq("fill_done", own_done, (c == 12) ? 1 : 0);
      check_eq("fill_done_other", oth_done, 0);
      check_eq("fill_busy", busy, (c <= 12) ? 1 : 0);
      if (c == 12 || c == drop_c) begin
        if (is_d) dc_req = 1'b0;
        else      ic_req = 1'b0;
      end
    end
    check_eq("fill_words_left", exp_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_mem_en"}, mem_en, 0);
    check_eq({tag, "_mem_wr"}, mem_wr, 0);
    check_eq({tag, "_ic_we"}, ic_fill_we, 0);
    check_eq({tag, "_dc_we"}, dc_fill_we, 0);
    check_eq({tag, "_ic_done"}, ic_done, 0);
    check_eq({tag, "_dc_done"}, dc_done, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    check_quiet("rst");
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_fill_word", fill_word, 0);
    check_eq("rst_fill_data", fill_data, 0);
    rst_n = 1'b1;
    step();
    check_quiet("idle");

    // I-side line fill, 0x1236 -> line 0x1230
    ic_addr = 16'h1236;
    ic_req  = 1'b1;
    do_fill(1'b0, 16'h1236, 0);

    // D-side write-through
    dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 16'h0040; dc_wdata = 16'hBEEF;
    check_eq("wr_pre_en", mem_en, 0);
    step();
    dc_addr = 16'h1111; dc_wdata = 16'h2222;   // must not leak into the write
    check_eq("wr_en", mem_en, 1);
    check_eq("wr_wr", mem_wr, 1);
    check_eq("wr_addr", mem_addr, 16'h0040);
    check_eq("wr_data", mem_wdata, 16'hBEEF);
    check_eq("wr_done", dc_done, 1);
    check_eq("wr_busy", busy, 1);
    dc_req = 1'b0; dc_wr = 1'b0;
    step();
    check_quiet("wr_after");

    // Fresh reset so the D side holds priority, then contend
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ic_addr = 16'h4000; ic_req = 1'b1;
    dc_addr = 16'h5010; dc_req = 1'b1; dc_wr = 1'b0;
    do_fill(1'b1, 16'h5010, 0);              // D first after reset
    dc_addr = 16'h6020; dc_req = 1'b1;       // D re-requests while I waits
    do_fill(1'b0, 16'h4000, 0);              // I must win this round
    do_fill(1'b1, 16'h6020, 0);              // then D again

    // Reset in the middle of a fill, during the 3rd returned word
    ic_addr = 16'h2000; ic_req = 1'b1;
    for (int c = 1; c <= 7; c++) step();
    check_eq("mid_we_pre", ic_fill_we, 1);
    check_eq("mid_word_pre", fill_word, 2);
    #1 rst_n = 1'b0;
    ic_req = 1'b0;
    #1;
    check_quiet("mid_rst");
    check_eq("mid_rst_addr", mem_addr, 0);
    check_eq("mid_rst_word", fill_word, 0);
    check_eq("mid_rst_data", fill_data, 0);
    #1 rst_n = 1'b1;
    spur_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_eq("late_valid_seen", mem_valid, 1);
      check_quiet("late");
    end
    spur_valid = 1'b0;
    ic_addr = 16'h3008; ic_req = 1'b1;
    do_fill(1'b0, 16'h3008, 0);

    // Spurious returns while idle
    spur_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_quiet("spur");
    end
    spur_valid = 1'b0;
    dc_addr = 16'h0A5C; dc_wr = 1'b0; dc_req = 1'b1;
    do_fill(1'b1, 16'h0A5C, 0);

    // I request withdrawn mid-fill still completes
    ic_addr = 16'h7FFE; ic_req = 1'b1;
    do_fill(1'b0, 16'h7FFE, 3);
    step();
    check_quiet("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
